// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Elastic pipeline-stage register carrying an opaque DATA_W payload between
//   two stages with a valid/ready handshake. With SKID=1 a second (skid) entry
//   absorbs the beat that arrives in the cycle downstream stalls, so in_ready
//   can come from a flop. With SKID=0 the stage is a single register and
//   in_ready is combinational. A synchronous flush empties the stage, and a
//   saturating counter records back-pressure cycles.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high, clears all state
//   flush      in   1       synchronous, drops held entries and this cycle's input beat
//   in_valid   in   1       upstream beat valid
//   in_ready   out  1       stage accepts a beat this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a valid beat
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  DATA_W  payload at the head of the stage
//   occupancy  out  2       held entries (0..2 with SKID=1, 0..1 with SKID=0)
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready, saturating

module pipe_stage_skid #(
  parameter int DATA_W = 101,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                rdy_q, rdy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  // Registered ready for the skid variant; gated by reset so the stage never
  // advertises space while it is being cleared.
  assign in_ready  = SKID ? (rdy_q & ~reset)
                          : (~reset & (~out_valid | out_ready));

  assign occupancy = SKID ? state_q : {1'b0, state_q[0]};
  assign stall_cnt = cnt_q;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins over any transfer; an output transfer this cycle has
      // still been seen by downstream, the input beat is simply dropped.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            // Only reachable with the skid entry present: in the single-
            // register variant a full stage accepts only when draining.
            if (SKID) begin
              state_d = ST_SKID;
              skid_d  = in_data;
            end
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign rdy_d = (state_d != ST_SKID);

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int DW  = 101;
  localparam int NDW = 16;

  logic clk;
  logic reset;

  // Main instance: SKID=1, default widths.
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  // Saturation instance: SKID=1, CNT_W=4.
  logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0]   s_in_data, s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_cnt;

  // Single-register instance: SKID=0.
  logic           n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [NDW-1:0] n_in_data, n_out_data;
  logic [1:0]     n_occupancy;
  logic [15:0]    n_stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  logic [DW-1:0]  q[$];
  logic [NDW-1:0] nq[$];

  pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u_main (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(32), .SKID(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(NDW), .SKID(1'b0), .CNT_W(16)) u_ns (
    .clk(clk), .reset(reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy), .stall_cnt(n_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the main instance, starting and ending at a falling edge.
  // The queue is the reference model of held entries (depth 2).
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ord, input logic fl);
    logic in_x, out_x;
    in_valid  = v;
    in_data   = d;
    out_ready = ord;
    flush     = fl;
    #1;
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("in_ready",  128'(in_ready),  128'(q.size() != 2));
    if (q.size() != 0) chk("out_data", 128'(out_data), 128'(q[0]));
    out_x = ord && (q.size() != 0);
    in_x  = v && (q.size() < 2);
    if ((q.size() != 0) && !ord) exp_stall++;
    if (out_x) void'(q.pop_front());
    if (fl) q.delete();
    else if (in_x) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0;
    n_flush = 0; n_in_valid = 0; n_in_data = '0; n_out_ready = 0;

    // Reset state
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_stall",     128'(stall_cnt), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // 1) Stream 8 beats with out_ready held high
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // 2) Back-pressure into the skid entry
    step(1'b1, DW'(101'hA), 1'b1, 1'b0);
    step(1'b1, DW'(101'hB), 1'b0, 1'b0);
    step(1'b1, DW'(101'hC), 1'b0, 1'b0);
    step(1'b1, DW'(101'hC), 1'b0, 1'b0);
    step(1'b1, DW'(101'hC), 1'b1, 1'b0);
    step(1'b1, DW'(101'hC), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_stall_exact", 128'(stall_cnt), 128'(3));

    // 3) Flush with two entries held and an input beat offered
    step(1'b1, DW'(101'h11), 1'b0, 1'b0);
    step(1'b1, DW'(101'h22), 1'b0, 1'b0);
    step(1'b1, DW'(101'h33), 1'b0, 1'b1);
    chk("flush_out_data", 128'(out_data), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_stall", 128'(stall_cnt), 128'(exp_stall));

    // 4) Asynchronous reset between edges with occupancy 2
    step(1'b1, DW'(101'h44), 1'b0, 1'b0);
    step(1'b1, DW'(101'h55), 1'b0, 1'b0);
    in_valid = 0; out_ready = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_occupancy", 128'(occupancy), 128'(0));
    chk("arst_stall",     128'(stall_cnt), 128'(0));
    chk("arst_in_ready",  128'(in_ready),  128'(0));
    q.delete();
    exp_stall = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    step(1'b0, '0, 1'b1, 1'b0);

    // 5) Counter saturation on a 4-bit counter
    s_in_valid = 1'b1;
    s_in_data  = 32'hABCD_0123;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      chk("sat_stall", 128'(s_stall_cnt), 128'((i < 15) ? i : 15));
    end
    chk("sat_data", 128'(s_out_data), 128'(32'hABCD_0123));
    @(negedge clk);

    // 6) Single-register variant, random traffic
    for (int i = 0; i < 1000; i++) begin
      logic exp_rdy, in_x, out_x;
      n_in_valid  = 1'($urandom_range(0, 1));
      n_in_data   = NDW'($urandom);
      n_out_ready = ($urandom_range(0, 3) != 0);
      n_flush     = ($urandom_range(0, 63) == 0);
      #1;
      exp_rdy = (nq.size() == 0) || n_out_ready;
      chk("ns_in_ready",  128'(n_in_ready),  128'(exp_rdy));
      chk("ns_out_valid", 128'(n_out_valid), 128'(nq.size() != 0));
      chk("ns_occupancy", 128'(n_occupancy), 128'(nq.size()));
      if (nq.size() != 0) chk("ns_out_data", 128'(n_out_data), 128'(nq[0]));
      out_x = n_out_ready && (nq.size() != 0);
      in_x  = n_in_valid && exp_rdy;
      if (out_x) void'(nq.pop_front());
      if (n_flush) nq.delete();
      else if (in_x) nq.push_back(n_in_data);
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
